// File: rtl/muldiv_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_pkg : MDop encodings, default latencies and FSM state type
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package muldiv_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'b000,
    MD_MULT  = 3'b001,
    MD_MULTU = 3'b010,
    MD_DIV   = 3'b011,
    MD_DIVU  = 3'b100,
    MD_MTHI  = 3'b101,
    MD_MTLO  = 3'b110,
    MD_RSVD  = 3'b111
  } md_op_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  localparam int MULT_LAT_DEFAULT = 5;
  localparam int DIV_LAT_DEFAULT  = 10;

  function automatic logic is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_calc.sv
// ---------------------------------------------------------------------------
// muldiv_calc : combinational 32x32 multiply / divide on latched operands
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module muldiv_calc
  import muldiv_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  md_op_e      op_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        div0_o
);

  logic        w_sgn;
  logic        w_neg_q;
  logic        w_neg_r;
  logic [63:0] w_prod;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [31:0] w_quot;
  logic [31:0] w_rem;

  // Signed divide works on magnitudes so 0x80000000 / -1 cannot overflow.
  always_comb begin
    w_sgn   = (op_i == MD_MULT) || (op_i == MD_DIV);
    w_prod  = w_sgn ? ({{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i})
                    : ({32'd0, a_i} * {32'd0, b_i});
    w_neg_q = w_sgn && (a_i[31] ^ b_i[31]);
    w_neg_r = w_sgn && a_i[31];
    w_mag_a = (w_sgn && a_i[31]) ? (32'd0 - a_i) : a_i;
    w_mag_b = (w_sgn && b_i[31]) ? (32'd0 - b_i) : b_i;
    div0_o  = is_div(op_i) && (b_i == 32'd0);
    w_quot  = (b_i == 32'd0) ? 32'd0 : (w_mag_a / w_mag_b);
    w_rem   = (b_i == 32'd0) ? 32'd0 : (w_mag_a % w_mag_b);
    hi_o    = w_prod[63:32];
    lo_o    = w_prod[31:0];
    if (is_div(op_i)) begin
      hi_o = w_neg_r ? (32'd0 - w_rem)  : w_rem;
      lo_o = w_neg_q ? (32'd0 - w_quot) : w_quot;
    end
  end

endmodule

`default_nettype wire

// File: rtl/muldiv_core.sv
// ---------------------------------------------------------------------------
// muldiv_core : multi-cycle MD unit with HI/LO registers and busy countdown
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module muldiv_core
  import muldiv_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEFAULT,
  parameter int DIV_LAT  = DIV_LAT_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] D1,
  input  logic [31:0] D2,
  input  logic [2:0]  MDop,
  input  logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int LAT_MAX = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW      = $clog2(LAT_MAX + 1);

  md_state_e   state_q;
  md_op_e      op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [CW-1:0] cnt_q;
  logic        busy_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  md_op_e      w_op_in;
  logic [31:0] w_hi;
  logic [31:0] w_lo;
  logic        w_div0;

  assign w_op_in = md_op_e'(MDop);

  muldiv_calc u_calc (
    .a_i    (a_q),
    .b_i    (b_q),
    .op_i   (op_q),
    .hi_o   (w_hi),
    .lo_o   (w_lo),
    .div0_o (w_div0)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      op_q    <= MD_NONE;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            case (w_op_in)
              MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                op_q    <= w_op_in;
                a_q     <= D1;
                b_q     <= D2;
                cnt_q   <= is_div(w_op_in) ? CW'(DIV_LAT) : CW'(MULT_LAT);
                busy_q  <= 1'b1;
                state_q <= ST_RUN;
              end
              MD_MTHI: hi_q <= D1;
              MD_MTLO: lo_q <= D1;
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          // start is ignored here; the hazard unit reissues it after busy drops
          if (cnt_q == CW'(1)) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
            if (!w_div0) begin
              hi_q <= w_hi;
              lo_q <= w_lo;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_core.sv
// ---------------------------------------------------------------------------
// tb_muldiv_core : directed stimulus with a queue-based completion scoreboard
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_muldiv_core;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] D1 = 32'd0;
  logic [31:0] D2 = 32'd0;
  logic [2:0]  MDop = 3'd0;
  logic        start = 1'b0;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int tests  = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  exp_t exp_q[$];

  muldiv_core dut (
    .Clk   (Clk),
    .Reset (Reset),
    .D1    (D1),
    .D2    (D2),
    .MDop  (MDop),
    .start (start),
    .busy  (busy),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    end
  endtask

  // Monitor: every falling edge of busy is a completion, unless reset caused it
  logic rst_at_edge = 1'b0;
  logic prev_busy   = 1'b0;
  int   busy_cnt    = 0;

  always @(posedge Clk) rst_at_edge <= Reset;

  always @(negedge Clk) begin
    exp_t e;
    if (busy === 1'b1) busy_cnt++;
    if (prev_busy && busy === 1'b0) begin
      if (!rst_at_edge) begin
        if (exp_q.size() == 0) begin
          tests++;
          errors++;
          $display("FAIL unexpected_completion: HI=0x%08h LO=0x%08h", HI, LO);
        end else begin
          e = exp_q.pop_front();
          check("commit_HI", HI, e.hi);
          check("commit_LO", LO, e.lo);
          check("busy_cycles", 32'(busy_cnt), 32'(e.lat));
        end
      end
      busy_cnt = 0;
    end
    if (busy !== 1'b1) busy_cnt = 0;
    prev_busy = (busy === 1'b1);
  end

  task automatic cyc();
    @(posedge Clk);
    #2;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    MDop  = op;
    D1    = a;
    D2    = b;
    cyc();
    start = 1'b0;
    MDop  = 3'b000;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 40) begin
      cyc();
      n++;
    end
    if (busy !== 1'b0) begin
      tests++;
      errors++;
      $display("FAIL wait_idle_timeout: busy=%b expected 0", busy);
    end
  endtask

  task automatic push(input logic [31:0] h, input logic [31:0] l, input int lat);
    exp_t e;
    e.hi = h;
    e.lo = l;
    e.lat = lat;
    exp_q.push_back(e);
  endtask

  initial begin
    cyc();
    cyc();
    Reset = 1'b0;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_HI", HI, 32'd0);
    check("reset_LO", LO, 32'd0);

    // mult -1 * 2
    push(32'hFFFF_FFFF, 32'hFFFF_FFFE, 5);
    issue(3'b001, 32'hFFFF_FFFF, 32'd2);
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    wait_idle();

    // multu same operands; D1 disturbed mid-flight
    push(32'h0000_0001, 32'hFFFF_FFFE, 5);
    issue(3'b010, 32'hFFFF_FFFF, 32'd2);
    D1 = 32'd0;
    wait_idle();

    // div -7 / 2
    push(32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    issue(3'b011, 32'hFFFF_FFF9, 32'd2);
    wait_idle();

    // divu 7 / 0 leaves HI/LO as they were
    push(32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    issue(3'b100, 32'd7, 32'd0);
    wait_idle();

    // mthi: immediate, no busy
    issue(3'b101, 32'h1234_5678, 32'd0);
    check("mthi_HI", HI, 32'h1234_5678);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    check("mthi_LO_kept", LO, 32'hFFFF_FFFD);

    // mult 3*4 with an ignored mult and mtlo during RUN
    push(32'd0, 32'd12, 5);
    issue(3'b001, 32'd3, 32'd4);
    issue(3'b001, 32'd5, 32'd6);
    issue(3'b110, 32'h0000_AAAA, 32'd0);
    wait_idle();
    // back-to-back reissue on the cycle after busy falls
    push(32'd0, 32'd30, 5);
    issue(3'b001, 32'd5, 32'd6);
    wait_idle();

    // signed overflow case
    push(32'd0, 32'h8000_0000, 10);
    issue(3'b011, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle();

    push(32'd0, 32'd6, 5);
    issue(3'b001, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
    wait_idle();
    push(32'h4000_0000, 32'd0, 5);
    issue(3'b001, 32'h8000_0000, 32'h8000_0000);
    wait_idle();
    push(32'hFFFF_FFFE, 32'h0000_0001, 5);
    issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle();
    push(32'd1, 32'hFFFF_FFFD, 10);
    issue(3'b011, 32'd7, 32'hFFFF_FFFE);
    wait_idle();
    push(32'd1, 32'h7FFF_FFFC, 10);
    issue(3'b100, 32'hFFFF_FFF9, 32'd2);
    wait_idle();

    // reserved op and none: no effect
    issue(3'b111, 32'hDEAD_BEEF, 32'd1);
    issue(3'b000, 32'hDEAD_BEEF, 32'd1);
    check("rsvd_busy", {31'd0, busy}, 32'd0);
    check("rsvd_HI", HI, 32'd1);
    check("rsvd_LO", LO, 32'h7FFF_FFFC);

    // reset in cycle 3 of a mult discards the result
    issue(3'b001, 32'd3, 32'd3);
    cyc();
    Reset = 1'b1;
    cyc();
    Reset = 1'b0;
    check("midrun_reset_busy", {31'd0, busy}, 32'd0);
    check("midrun_reset_HI", HI, 32'd0);
    check("midrun_reset_LO", LO, 32'd0);
    repeat (8) cyc();
    check("no_late_commit_HI", HI, 32'd0);
    check("no_late_commit_LO", LO, 32'd0);

    repeat (2) cyc();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

`default_nettype wire
